mda_crtc: RTL and testbench

- Configuration and sequencing controller for the MDA text video datapath: MC6845-compatible index/data register file plus MDA mode-control and status ports at I/O 0x3B0-0x3BF.
- Supplies start address, cursor position/shape, blink phases and enable bits to the character/font pipeline.
- Runs entirely in the CPU clock domain; the video side re-synchronises its outputs.

---
 rtl/mda_crtc.sv | 167 ++++++++++++++++
 tb/tb_mda_crtc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mda_crtc.sv
// ============================================================================
// mda_crtc : MDA CRTC register file, mode/status ports and blink sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module mda_crtc #(
  parameter logic [15:0] IO_BASE        = 16'h03B0,
  parameter int          BLINK_SLOW_BIT = 4,
  parameter int          BLINK_FAST_BIT = 3
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [15:0] iAddr,
  input  logic [7:0]  iData,
  input  logic        iIoWr,
  input  logic        iIoRd,
  output logic [7:0]  oData,
  output logic        oDataValid,
  input  logic        iVSync,
  input  logic        iHSync,
  input  logic        iVideo,
  output logic [13:0] oStartAddr,
  output logic [13:0] oCursorAddr,
  output logic [4:0]  oCursorStart,
  output logic [4:0]  oCursorEnd,
  output logic [4:0]  oMaxScan,
  output logic        oCursorOn,
  output logic        oBlinkPhase,
  output logic        oVideoEn,
  output logic        oBlinkEn,
  output logic        oHiRes
);

  // Only R0-R15 are stored; R16/R17 are read-only and always read as zero.
  logic [7:0] crtc_q [16];
  logic [7:0] crtc_d [16];
  logic [4:0] index_q, index_d;
  logic [5:0] mode_q, mode_d;
  logic [4:0] counter_q, counter_d;
  logic       vs_q, vs_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  logic       in_win;
  logic [3:0] offset;
  logic       is_index, is_data, is_mode, is_status;
  logic       vs_rise;
  logic [7:0] rd_val;
  logic       unused_bits;

  function automatic logic [7:0] keep_mask(input logic [3:0] idx);
    case (idx)
      4'd12, 4'd14: keep_mask = 8'h3F;
      4'd10:        keep_mask = 8'h7F;
      4'd9, 4'd11:  keep_mask = 8'h1F;
      default:      keep_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] reg_default(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_default = 8'h61;
      4'd1:    reg_default = 8'h50;
      4'd2:    reg_default = 8'h52;
      4'd3:    reg_default = 8'h0F;
      4'd4:    reg_default = 8'h19;
      4'd5:    reg_default = 8'h06;
      4'd6:    reg_default = 8'h19;
      4'd7:    reg_default = 8'h19;
      4'd8:    reg_default = 8'h02;
      4'd9:    reg_default = 8'h0D;
      4'd10:   reg_default = 8'h0B;
      4'd11:   reg_default = 8'h0C;
      default: reg_default = 8'h00;
    endcase
  endfunction

  assign in_win    = (iAddr[15:4] == IO_BASE[15:4]);
  assign offset    = iAddr[3:0];
  assign is_index  = in_win && !offset[3] && !offset[0];
  assign is_data   = in_win && !offset[3] &&  offset[0];
  assign is_mode   = in_win && (offset == 4'h8);
  assign is_status = in_win && (offset == 4'hA);
  assign vs_rise   = iVSync && !vs_q;

  always_comb begin
    rd_val = 8'hFF;
    if (is_index) begin
      rd_val = {3'b000, index_q};
    end else if (is_data) begin
      if (index_q == 5'd14)      rd_val = crtc_q[14];
      else if (index_q == 5'd15) rd_val = crtc_q[15];
      else                       rd_val = 8'h00;
    end else if (is_status) begin
      rd_val = {4'hF, iVideo, 2'b00, iHSync};
    end
  end

  // A write wins over a simultaneous read; the read is dropped entirely.
  always_comb begin
    crtc_d    = crtc_q;
    index_d   = index_q;
    mode_d    = mode_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    vs_d      = iVSync;
    counter_d = counter_q + {4'b0000, vs_rise};
    if (iIoWr) begin
      if (is_index) index_d = iData[4:0];
      if (is_data && !index_q[4]) crtc_d[index_q[3:0]] = iData & keep_mask(index_q[3:0]);
      if (is_mode) mode_d = iData[5:0];
    end else if (iIoRd) begin
      valid_d = 1'b1;
      data_d  = rd_val;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      for (int i = 0; i < 16; i++) crtc_q[i] <= reg_default(4'(i));
      index_q   <= 5'd0;
      mode_q    <= 6'd0;
      counter_q <= 5'd0;
      vs_q      <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      crtc_q    <= crtc_d;
      index_q   <= index_d;
      mode_q    <= mode_d;
      counter_q <= counter_d;
      vs_q      <= vs_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    oCursorOn = 1'b1;
    case (crtc_q[10][6:5])
      2'b00: oCursorOn = 1'b1;
      2'b01: oCursorOn = 1'b0;
      2'b10: oCursorOn = counter_q[BLINK_FAST_BIT];
      2'b11: oCursorOn = counter_q[BLINK_SLOW_BIT];
      default: oCursorOn = 1'b1;
    endcase
  end

  assign oData        = data_q;
  assign oDataValid   = valid_q;
  assign oStartAddr   = {crtc_q[12][5:0], crtc_q[13]};
  assign oCursorAddr  = {crtc_q[14][5:0], crtc_q[15]};
  assign oCursorStart = crtc_q[10][4:0];
  assign oCursorEnd   = crtc_q[11][4:0];
  assign oMaxScan     = crtc_q[9][4:0];
  assign oBlinkPhase  = counter_q[BLINK_SLOW_BIT];
  assign oVideoEn     = mode_q[3];
  assign oBlinkEn     = mode_q[5];
  assign oHiRes       = mode_q[0];

  assign unused_bits = ^{mode_q[4], mode_q[2:1], crtc_q[12][7:6], crtc_q[10][7],
                         crtc_q[9][7:5], crtc_q[11][7:5]};

endmodule

`default_nettype wire

// File: tb/tb_mda_crtc.sv
// ============================================================================
// tb_mda_crtc : directed + randomized check of mda_crtc against a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mda_crtc;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wr, rd, vs, hs, vid;
  logic [7:0]  o_data;
  logic        o_valid;
  logic [13:0] o_start, o_caddr;
  logic [4:0]  o_cstart, o_cend, o_maxscan;
  logic        o_con, o_bphase, o_ven, o_ben, o_hires;

  always #5 clk = ~clk;

  mda_crtc dut (
    .iClk(clk), .iRstN(rstn), .iAddr(addr), .iData(wdata), .iIoWr(wr), .iIoRd(rd),
    .oData(o_data), .oDataValid(o_valid), .iVSync(vs), .iHSync(hs), .iVideo(vid),
    .oStartAddr(o_start), .oCursorAddr(o_caddr), .oCursorStart(o_cstart),
    .oCursorEnd(o_cend), .oMaxScan(o_maxscan), .oCursorOn(o_con),
    .oBlinkPhase(o_bphase), .oVideoEn(o_ven), .oBlinkEn(o_ben), .oHiRes(o_hires)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the full programmer-visible register file R0-R17.
  int mreg [18];
  int midx, mmode, mcnt, mvs, mdata, mvalid;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int kept_bits(input int r);
    if (r == 12 || r == 14) return 6;
    if (r == 10) return 7;
    if (r == 9 || r == 11) return 5;
    return 8;
  endfunction

  task automatic model_clock();
    int defaults [18];
    int off;
    bit win;
    defaults = '{'h61, 'h50, 'h52, 'h0F, 'h19, 'h06, 'h19, 'h19, 'h02,
                 'h0D, 'h0B, 'h0C, 0, 0, 0, 0, 0, 0};
    if (!rstn) begin
      mreg = defaults;
      midx = 0; mmode = 0; mcnt = 0; mvs = 0; mdata = 0; mvalid = 0;
      return;
    end
    win = (addr / 16) == ('h3B0 / 16);
    off = addr % 16;
    mvalid = 0;
    if (wr) begin
      if (win && off < 8 && off % 2 == 0) midx = wdata % 32;
      else if (win && off < 8 && midx <= 15) mreg[midx] = wdata % (1 << kept_bits(midx));
      else if (win && off == 8) mmode = wdata % 64;
    end else if (rd) begin
      mvalid = 1;
      if (!win) mdata = 'hFF;
      else if (off < 8 && off % 2 == 0) mdata = midx;
      else if (off < 8) mdata = (midx == 14 || midx == 15) ? mreg[midx] : 0;
      else if (off == 10) mdata = 'hF0 + 8 * vid + hs;
      else mdata = 'hFF;
    end
    if (vs && !mvs) mcnt = (mcnt + 1) % 32;
    mvs = vs;
  endtask

  task automatic check_outputs();
    int cmode, exp_con;
    cmode = (mreg[10] / 32) % 4;
    case (cmode)
      0: exp_con = 1;
      1: exp_con = 0;
      2: exp_con = (mcnt / 8) % 2;
      default: exp_con = (mcnt / 16) % 2;
    endcase
    check_eq("data_valid", o_valid, mvalid);
    check_eq("data", o_data, mdata);
    check_eq("start_addr", o_start, (mreg[12] % 64) * 256 + mreg[13]);
    check_eq("cursor_addr", o_caddr, (mreg[14] % 64) * 256 + mreg[15]);
    check_eq("cursor_start", o_cstart, mreg[10] % 32);
    check_eq("cursor_end", o_cend, mreg[11] % 32);
    check_eq("max_scan", o_maxscan, mreg[9] % 32);
    check_eq("cursor_on", o_con, exp_con);
    check_eq("blink_phase", o_bphase, (mcnt / 16) % 2);
    check_eq("video_en", o_ven, (mmode / 8) % 2);
    check_eq("blink_en", o_ben, (mmode / 32) % 2);
    check_eq("hi_res", o_hires, mmode % 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
    step();
    wr = 1'b0;
  endtask

  task automatic io_rd(input logic [15:0] a);
    addr = a; rd = 1'b1; wr = 1'b0;
    step();
    rd = 1'b0;
  endtask

  task automatic vs_pulse();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  initial begin
    rstn = 1'b0; addr = 16'h0; wdata = 8'h0; wr = 1'b0; rd = 1'b0;
    vs = 1'b0; hs = 1'b0; vid = 1'b0;
    #2;
    wr = 1'b1; addr = 16'h03B8; wdata = 8'hFF;
    step(); step();
    wr = 1'b0;
    rstn = 1'b1;
    step();
    check_eq("rst_maxscan_lit", o_maxscan, 'h0D);
    check_eq("rst_cstart_lit", o_cstart, 'h0B);
    check_eq("rst_cend_lit", o_cend, 'h0C);
    check_eq("rst_ven_lit", o_ven, 0);
    check_eq("rst_con_lit", o_con, 1);
    check_eq("rst_start_lit", o_start, 0);

    io_wr(16'h03B4, 8'h0E); io_wr(16'h03B5, 8'hFF);
    io_wr(16'h03B4, 8'h0F); io_wr(16'h03B5, 8'h34);
    check_eq("caddr_lit", o_caddr, 'h3F34);
    io_rd(16'h03B5);
    check_eq("rd_r15_lit", o_data, 'h34);
    check_eq("rd_r15_valid_lit", o_valid, 1);
    step();
    check_eq("valid_drop_lit", o_valid, 0);
    io_wr(16'h03B4, 8'h0E); io_rd(16'h03B5);
    check_eq("rd_r14_lit", o_data, 'h3F);

    io_wr(16'h03B8, 8'h29);
    check_eq("hires_lit", o_hires, 1);
    check_eq("ven_lit", o_ven, 1);
    check_eq("ben_lit", o_ben, 1);
    hs = 1'b1; vid = 1'b0; io_rd(16'h03BA);
    check_eq("status_f1_lit", o_data, 'hF1);
    hs = 1'b0; vid = 1'b1; io_rd(16'h03BA);
    check_eq("status_f8_lit", o_data, 'hF8);

    io_wr(16'h03B4, 8'h0A); io_wr(16'h03B5, 8'h4B);
    check_eq("fast_blink_c0_lit", o_con, 0);
    for (int i = 0; i < 8; i++) vs_pulse();
    check_eq("fast_blink_c8_lit", o_con, 1);
    vs = 1'b1;
    for (int i = 0; i < 20; i++) step();
    vs = 1'b0; step();
    check_eq("hold_counts_once_lit", o_con, 1);
    io_wr(16'h03B5, 8'h2B);
    check_eq("cursor_off_lit", o_con, 0);
    check_eq("bphase_before_lit", o_bphase, 0);
    for (int i = 0; i < 16; i++) vs_pulse();
    check_eq("bphase_after_lit", o_bphase, 1);

    io_wr(16'h03B4, 8'h18); io_wr(16'h03B5, 8'h55); io_rd(16'h03B5);
    check_eq("rd_idx18_lit", o_data, 'h00);
    io_rd(16'h03BC);
    check_eq("rd_3bc_lit", o_data, 'hFF);
    io_rd(16'h03C0);
    check_eq("rd_outside_lit", o_data, 'hFF);
    check_eq("rd_outside_valid_lit", o_valid, 1);
    io_wr(16'h03B4, 8'h0F);
    addr = 16'h03B5; wdata = 8'h77; wr = 1'b1; rd = 1'b1;
    step();
    wr = 1'b0; rd = 1'b0;
    check_eq("wr_rd_valid_lit", o_valid, 0);
    check_eq("wr_rd_landed_lit", o_caddr % 256, 'h77);

    io_wr(16'h03B4, 8'h0C); io_wr(16'h03B5, 8'h12); io_wr(16'h03B8, 8'h29);
    rstn = 1'b0; step(); rstn = 1'b1;
    check_eq("mid_rst_start_lit", o_start, 0);
    check_eq("mid_rst_ven_lit", o_ven, 0);
    check_eq("mid_rst_bphase_lit", o_bphase, 0);
    check_eq("mid_rst_con_lit", o_con, 1);

    for (int i = 0; i < 4000; i++) begin
      rstn  = ($urandom_range(0, 249) != 0);
      addr  = ($urandom_range(0, 9) != 0) ? (16'h03B0 + 16'($urandom_range(0, 15)))
                                          : 16'($urandom);
      wdata = 8'($urandom);
      if ($urandom_range(0, 3) == 0) wdata = 8'($urandom_range(9, 18));
      wr    = ($urandom_range(0, 2) == 0);
      rd    = ($urandom_range(0, 2) == 0);
      hs    = 1'($urandom);
      vid   = 1'($urandom);
      if ($urandom_range(0, 3) == 0) vs = ~vs;
      step();
    end
    wr = 1'b0; rd = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
